// File: rtl/mmu_pkg.sv
// mmu_pkg: shared definitions for the MIPS virtual-to-physical translator.
//   - exception codes driven on rsp_exc
//   - segment encodings of vaddr[31:29] for the unmapped kernel segments
//   - VPN/PFN widths and the TLB entry record
// The entry's ASID field is sized to ASID_MAX_W so the struct stays fixed;
// the top zero-extends its ASID_W-wide values into it (ASID_W <= ASID_MAX_W).
package mmu_pkg;

    localparam int VPN_W      = 20;
    localparam int PFN_W      = 20;
    localparam int ASID_MAX_W = 16;

    localparam logic [2:0] EXC_NONE        = 3'd0;
    localparam logic [2:0] EXC_ADDR_ERR    = 3'd1;
    localparam logic [2:0] EXC_TLB_REFILL  = 3'd2;
    localparam logic [2:0] EXC_TLB_INVALID = 3'd3;
    localparam logic [2:0] EXC_TLB_MOD     = 3'd4;

    localparam logic [2:0] SEG_KSEG0 = 3'b100;
    localparam logic [2:0] SEG_KSEG1 = 3'b101;

    typedef struct packed {
        logic [VPN_W-1:0]      vpn;
        logic [ASID_MAX_W-1:0] asid;
        logic                  g;     // global: ignore ASID on match
        logic [PFN_W-1:0]      pfn;
        logic                  v;     // valid
        logic                  d;     // dirty (write enable)
        logic                  uc;    // uncached
    } tlb_entry;

endpackage

// File: rtl/tlb_cam.sv
// tlb_cam: combinational match of one query against every TLB entry.
// Ports:
//   entries_i  all TLB entries
//   vpn_i      query virtual page number
//   asid_i     query ASID (zero-extended to ASID_MAX_W)
//   hit_o      at least one entry matches (V bit is not considered)
//   idx_o      lowest matching index, 0 when no match
//   entry_o    contents of entry idx_o
module tlb_cam
    import mmu_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  tlb_entry               entries_i [ENTRIES],
    input  logic [VPN_W-1:0]       vpn_i,
    input  logic [ASID_MAX_W-1:0]  asid_i,
    output logic                   hit_o,
    output logic [IDX_W-1:0]       idx_o,
    output tlb_entry               entry_o
);

    logic [ENTRIES-1:0] match;

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_match
            assign match[gi] = (entries_i[gi].vpn == vpn_i) &&
                               (entries_i[gi].g || (entries_i[gi].asid == asid_i));
        end
    endgenerate

    // Scan downwards so the last assignment is the lowest matching index.
    always_comb begin
        idx_o = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (match[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

    assign hit_o   = |match;
    assign entry_o = entries_i[idx_o];

endmodule

// File: rtl/mmu_xlate.sv
// mmu_xlate: MIPS virtual-to-physical address translator with a fully
// associative TLB, CP0 write/probe ports and a Random index counter.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   req_* / user_mode / cur_asid  translation request (sampled each edge)
//   rsp_*                         registered response, one cycle later
//   tlb_w*                        indexed / random TLB entry write
//   probe_* (in)                  probe request; probe_done/hit/index results
//   random_o                      current Random register value
// Optional build macro MMU_STATS_EN adds stat_hit / stat_miss saturating
// counters (mapped hits and TLB refills respectively).
module mmu_xlate
    import mmu_pkg::*;
#(
    parameter int TLB_ENTRIES = 16,
    parameter int IDX_W       = $clog2(TLB_ENTRIES),
    parameter int ASID_W      = 8,
    parameter int WIRED       = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [31:0]       req_addr,
    input  logic              req_write,
    input  logic              user_mode,
    input  logic [ASID_W-1:0] cur_asid,
    output logic              rsp_valid,
    output logic [31:0]       rsp_paddr,
    output logic              rsp_uncached,
    output logic [2:0]        rsp_exc,
    input  logic              tlb_we,
    input  logic              tlb_wrandom,
    input  logic [IDX_W-1:0]  tlb_windex,
    input  logic [19:0]       tlb_wvpn,
    input  logic [ASID_W-1:0] tlb_wasid,
    input  logic              tlb_wglobal,
    input  logic [19:0]       tlb_wpfn,
    input  logic              tlb_wvalid,
    input  logic              tlb_wdirty,
    input  logic              tlb_wuncached,
    input  logic              probe_valid,
    input  logic [19:0]       probe_vpn,
    input  logic [ASID_W-1:0] probe_asid,
    output logic              probe_done,
    output logic              probe_hit,
    output logic [IDX_W-1:0]  probe_index,
    output logic [IDX_W-1:0]  random_o
`ifdef MMU_STATS_EN
    ,
    output logic [31:0]       stat_hit,
    output logic [31:0]       stat_miss
`endif
);

    tlb_entry         entries_q [TLB_ENTRIES];
    tlb_entry         wr_entry;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] random_q, random_d;

    // ---------------- Random counter ----------------
    assign random_d = (random_q == IDX_W'(WIRED)) ? IDX_W'(TLB_ENTRIES - 1)
                                                  : random_q - 1'b1;
    assign random_o = random_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            random_q <= IDX_W'(TLB_ENTRIES - 1);
        end else begin
            random_q <= random_d;
        end
    end

    // ---------------- TLB storage ----------------
    assign wr_idx   = tlb_wrandom ? random_q : tlb_windex;
    assign wr_entry = '{vpn:  tlb_wvpn,
                        asid: ASID_MAX_W'(tlb_wasid),
                        g:    tlb_wglobal,
                        pfn:  tlb_wpfn,
                        v:    tlb_wvalid,
                        d:    tlb_wdirty,
                        uc:   tlb_wuncached};

    generate
        for (genvar gi = 0; gi < TLB_ENTRIES; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    entries_q[gi] <= '0;
                end else if (tlb_we && (wr_idx == IDX_W'(gi))) begin
                    entries_q[gi] <= wr_entry;
                end
            end
        end
    endgenerate

    // ---------------- Lookup and probe CAMs (pre-write contents) ----------------
    logic             lk_hit, pr_hit;
    logic [IDX_W-1:0] lk_idx_unused, pr_idx;
    tlb_entry         lk_entry, pr_entry_unused;
    logic             lk_fields_unused;

    tlb_cam #(.ENTRIES(TLB_ENTRIES), .IDX_W(IDX_W)) u_cam_lookup (
        .entries_i (entries_q),
        .vpn_i     (req_addr[31:12]),
        .asid_i    (ASID_MAX_W'(cur_asid)),
        .hit_o     (lk_hit),
        .idx_o     (lk_idx_unused),
        .entry_o   (lk_entry)
    );

    tlb_cam #(.ENTRIES(TLB_ENTRIES), .IDX_W(IDX_W)) u_cam_probe (
        .entries_i (entries_q),
        .vpn_i     (probe_vpn),
        .asid_i    (ASID_MAX_W'(probe_asid)),
        .hit_o     (pr_hit),
        .idx_o     (pr_idx),
        .entry_o   (pr_entry_unused)
    );

    // Match fields of the looked-up entry are only needed inside the CAM.
    assign lk_fields_unused = ^{lk_entry.vpn, lk_entry.asid, lk_entry.g};

    // ---------------- Translation ----------------
    logic [2:0]  seg;
    logic        addr_err, unmapped;
    logic [2:0]  exc_d;
    logic [31:0] paddr_d;
    logic        uc_d;

    assign seg      = req_addr[31:29];
    assign addr_err = user_mode && req_addr[31];
    assign unmapped = (seg == SEG_KSEG0) || (seg == SEG_KSEG1);

    always_comb begin
        exc_d   = EXC_NONE;
        paddr_d = '0;
        uc_d    = 1'b0;
        if (addr_err) begin
            exc_d = EXC_ADDR_ERR;
        end else if (unmapped) begin
            paddr_d = {3'b000, req_addr[28:0]};
            uc_d    = (seg == SEG_KSEG1);
        end else if (!lk_hit) begin
            exc_d = EXC_TLB_REFILL;
        end else if (!lk_entry.v) begin
            exc_d = EXC_TLB_INVALID;
        end else if (req_write && !lk_entry.d) begin
            exc_d = EXC_TLB_MOD;
        end else begin
            paddr_d = {lk_entry.pfn, req_addr[11:0]};
            uc_d    = lk_entry.uc;
        end
    end

    // ---------------- Registered responses ----------------
    logic             rsp_valid_q, rsp_uc_q, probe_done_q, probe_hit_q;
    logic [31:0]      rsp_paddr_q;
    logic [2:0]       rsp_exc_q;
    logic [IDX_W-1:0] probe_index_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q   <= 1'b0;
            rsp_paddr_q   <= '0;
            rsp_uc_q      <= 1'b0;
            rsp_exc_q     <= EXC_NONE;
            probe_done_q  <= 1'b0;
            probe_hit_q   <= 1'b0;
            probe_index_q <= '0;
        end else begin
            rsp_valid_q   <= req_valid;
            rsp_paddr_q   <= req_valid ? paddr_d : '0;
            rsp_uc_q      <= req_valid && uc_d;
            rsp_exc_q     <= req_valid ? exc_d : EXC_NONE;
            probe_done_q  <= probe_valid;
            probe_hit_q   <= probe_valid && pr_hit;
            probe_index_q <= (probe_valid && pr_hit) ? pr_idx : '0;
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_paddr    = rsp_paddr_q;
    assign rsp_uncached = rsp_uc_q;
    assign rsp_exc      = rsp_exc_q;
    assign probe_done   = probe_done_q;
    assign probe_hit    = probe_hit_q;
    assign probe_index  = probe_index_q;

`ifdef MMU_STATS_EN
    // ---------------- Statistics ----------------
    logic [31:0] stat_hit_q, stat_miss_q;
    logic        count_hit, count_miss;

    assign count_hit  = req_valid && !addr_err && !unmapped && (exc_d == EXC_NONE);
    assign count_miss = req_valid && (exc_d == EXC_TLB_REFILL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_hit_q  <= '0;
            stat_miss_q <= '0;
        end else begin
            if (count_hit && (stat_hit_q != '1)) begin
                stat_hit_q <= stat_hit_q + 32'd1;
            end
            if (count_miss && (stat_miss_q != '1)) begin
                stat_miss_q <= stat_miss_q + 32'd1;
            end
        end
    end

    assign stat_hit  = stat_hit_q;
    assign stat_miss = stat_miss_q;
`endif

endmodule

// File: tb/tb_mmu_xlate.sv
// Self-checking bench for mmu_xlate (TLB_ENTRIES=16, WIRED=4): directed
// scenarios followed by randomized traffic, all checked against a
// behavioural TLB model held in plain arrays.
module tb_mmu_xlate;

    localparam int ENT = 16;
    localparam int IW  = 4;
    localparam int AW  = 8;
    localparam int WIR = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic [31:0]   req_addr = '0;
    logic          req_write = 1'b0;
    logic          user_mode = 1'b0;
    logic [AW-1:0] cur_asid = '0;
    logic          rsp_valid;
    logic [31:0]   rsp_paddr;
    logic          rsp_uncached;
    logic [2:0]    rsp_exc;
    logic          tlb_we = 1'b0;
    logic          tlb_wrandom = 1'b0;
    logic [IW-1:0] tlb_windex = '0;
    logic [19:0]   tlb_wvpn = '0;
    logic [AW-1:0] tlb_wasid = '0;
    logic          tlb_wglobal = 1'b0;
    logic [19:0]   tlb_wpfn = '0;
    logic          tlb_wvalid = 1'b0;
    logic          tlb_wdirty = 1'b0;
    logic          tlb_wuncached = 1'b0;
    logic          probe_valid = 1'b0;
    logic [19:0]   probe_vpn = '0;
    logic [AW-1:0] probe_asid = '0;
    logic          probe_done;
    logic          probe_hit;
    logic [IW-1:0] probe_index;
    logic [IW-1:0] random_o;
`ifdef MMU_STATS_EN
    logic [31:0]   stat_hit;
    logic [31:0]   stat_miss;
`endif

    mmu_xlate #(.TLB_ENTRIES(ENT), .IDX_W(IW), .ASID_W(AW), .WIRED(WIR)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_write     (req_write),
        .user_mode     (user_mode),
        .cur_asid      (cur_asid),
        .rsp_valid     (rsp_valid),
        .rsp_paddr     (rsp_paddr),
        .rsp_uncached  (rsp_uncached),
        .rsp_exc       (rsp_exc),
        .tlb_we        (tlb_we),
        .tlb_wrandom   (tlb_wrandom),
        .tlb_windex    (tlb_windex),
        .tlb_wvpn      (tlb_wvpn),
        .tlb_wasid     (tlb_wasid),
        .tlb_wglobal   (tlb_wglobal),
        .tlb_wpfn      (tlb_wpfn),
        .tlb_wvalid    (tlb_wvalid),
        .tlb_wdirty    (tlb_wdirty),
        .tlb_wuncached (tlb_wuncached),
        .probe_valid   (probe_valid),
        .probe_vpn     (probe_vpn),
        .probe_asid    (probe_asid),
        .probe_done    (probe_done),
        .probe_hit     (probe_hit),
        .probe_index   (probe_index),
        .random_o      (random_o)
`ifdef MMU_STATS_EN
        ,
        .stat_hit      (stat_hit),
        .stat_miss     (stat_miss)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- Reference model ----------------
    logic [19:0]   m_vpn  [ENT];
    logic [AW-1:0] m_asid [ENT];
    logic          m_g    [ENT];
    logic [19:0]   m_pfn  [ENT];
    logic          m_v    [ENT];
    logic          m_d    [ENT];
    logic          m_uc   [ENT];

    // Rising edges seen since reset was released.
    int n_edges = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n_edges <= 0;
        else        n_edges <= n_edges + 1;
    end

    // Random walks 15 down to WIRED then wraps: period ENT-WIR.
    function automatic int rnd_model();
        return (ENT - 1) - (n_edges % (ENT - WIR));
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < ENT; i++) begin
            m_vpn[i] = '0; m_asid[i] = '0; m_g[i] = 1'b0; m_pfn[i] = '0;
            m_v[i] = 1'b0; m_d[i] = 1'b0; m_uc[i] = 1'b0;
        end
    endfunction

    function automatic int find(input logic [19:0] vpn, input logic [AW-1:0] asid);
        for (int i = 0; i < ENT; i++) begin
            if (m_vpn[i] == vpn && (m_g[i] || m_asid[i] == asid)) return i;
        end
        return -1;
    endfunction

    function automatic void ref_xlate(input logic [31:0] a, input logic w, input logic u,
                                      input logic [AW-1:0] asid, output logic [2:0] exc,
                                      output logic [31:0] pa, output logic uc);
        int k;
        exc = 3'd0; pa = '0; uc = 1'b0;
        if (u && a >= 32'h8000_0000) begin
            exc = 3'd1;
        end else if (a >= 32'h8000_0000 && a < 32'hC000_0000) begin
            pa = a & 32'h1FFF_FFFF;
            uc = (a >= 32'hA000_0000);
        end else begin
            k = find(a[31:12], asid);
            if (k < 0)               exc = 3'd2;
            else if (!m_v[k])        exc = 3'd3;
            else if (w && !m_d[k])   exc = 3'd4;
            else begin
                pa = {m_pfn[k], a[11:0]};
                uc = m_uc[k];
            end
        end
    endfunction

    // ---------------- Checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One clock: compute expectations from the pre-edge model, clock,
    // check everything, then apply any write to the model.
    task automatic tick();
        logic        e_rv, e_pd, e_uc, e_ph;
        logic [2:0]  e_exc;
        logic [31:0] e_pa;
        int          pk, widx;
        logic        we;
        e_rv = req_valid; e_pd = probe_valid; e_exc = '0; e_pa = '0; e_uc = 1'b0;
        if (req_valid) ref_xlate(req_addr, req_write, user_mode, cur_asid, e_exc, e_pa, e_uc);
        pk   = find(probe_vpn, probe_asid);
        e_ph = (pk >= 0);
        we   = tlb_we;
        widx = tlb_wrandom ? rnd_model() : int'(tlb_windex);
        @(posedge clk); #1;
        check("rsp_valid", 32'(rsp_valid), 32'(e_rv));
        if (e_rv) begin
            check("rsp_exc", 32'(rsp_exc), 32'(e_exc));
            check("rsp_paddr", rsp_paddr, e_pa);
            check("rsp_uncached", 32'(rsp_uncached), 32'(e_uc));
        end
        check("probe_done", 32'(probe_done), 32'(e_pd));
        if (e_pd) begin
            check("probe_hit", 32'(probe_hit), 32'(e_ph));
            check("probe_index", 32'(probe_index), e_ph ? 32'(pk) : 32'd0);
        end
        check("random", 32'(random_o), 32'(rnd_model()));
        if (we) begin
            m_vpn[widx] = tlb_wvpn; m_asid[widx] = tlb_wasid; m_g[widx] = tlb_wglobal;
            m_pfn[widx] = tlb_wpfn; m_v[widx] = tlb_wvalid; m_d[widx] = tlb_wdirty;
            m_uc[widx] = tlb_wuncached;
        end
        $display("[TB] t=%0t req=%0b addr=%08h exc=%0d pa=%08h pr=%0b hit=%0b idx=%0d rnd=%0d",
                 $time, e_rv, req_addr, rsp_exc, rsp_paddr, e_pd, probe_hit, probe_index, random_o);
        req_valid = 1'b0; probe_valid = 1'b0; tlb_we = 1'b0; tlb_wrandom = 1'b0;
    endtask

    task automatic set_req(input logic [31:0] a, input logic w, input logic u, input logic [AW-1:0] asid);
        req_valid = 1'b1; req_addr = a; req_write = w; user_mode = u; cur_asid = asid;
    endtask

    task automatic set_wr(input logic rnd, input logic [IW-1:0] idx, input logic [19:0] vpn,
                          input logic [AW-1:0] asid, input logic g, input logic [19:0] pfn,
                          input logic v, input logic d, input logic uc);
        tlb_we = 1'b1; tlb_wrandom = rnd; tlb_windex = idx; tlb_wvpn = vpn; tlb_wasid = asid;
        tlb_wglobal = g; tlb_wpfn = pfn; tlb_wvalid = v; tlb_wdirty = d; tlb_wuncached = uc;
    endtask

    task automatic set_probe(input logic [19:0] vpn, input logic [AW-1:0] asid);
        probe_valid = 1'b1; probe_vpn = vpn; probe_asid = asid;
    endtask

    function automatic logic [19:0] pick_vpn();
        case ($urandom_range(0, 5))
            0: return 20'h00400;
            1: return 20'h00401;
            2: return 20'hC0010;
            3: return 20'hE0020;
            4: return 20'h7FFFF;
            default: return 20'h00777;
        endcase
    endfunction

    // ---------------- Stimulus ----------------
    initial begin
        int guard;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_paddr", rsp_paddr, 32'd0);
        check("reset_rsp_exc", 32'(rsp_exc), 32'd0);
        check("reset_probe_done", 32'(probe_done), 32'd0);
        check("reset_random", 32'(random_o), 32'd15);
        @(negedge clk) rst_n = 1'b1;

        // Unmapped kernel segments.
        set_req(32'h8000_1234, 1'b0, 1'b0, 8'd0); tick();
        check("kseg0_paddr", rsp_paddr, 32'h0000_1234);
        set_req(32'hA000_1234, 1'b0, 1'b0, 8'd0); tick();
        check("kseg1_uncached", 32'(rsp_uncached), 32'd1);

        // Address error only in user mode.
        set_req(32'h8000_0000, 1'b0, 1'b1, 8'd0); tick();
        check("user_addr_err", 32'(rsp_exc), 32'd1);
        set_req(32'h8000_0000, 1'b0, 1'b0, 8'd0); tick();

        // Indexed write, hit, store fault, ASID mismatch.
        set_wr(1'b0, 4'd3, 20'h00400, 8'd5, 1'b0, 20'h12345, 1'b1, 1'b0, 1'b0); tick();
        set_req(32'h0040_0ABC, 1'b0, 1'b0, 8'd5); tick();
        check("tlb_hit_paddr", rsp_paddr, 32'h1234_5ABC);
        set_req(32'h0040_0ABC, 1'b1, 1'b0, 8'd5); tick();
        check("tlb_mod", 32'(rsp_exc), 32'd4);
        set_req(32'h0040_0ABC, 1'b0, 1'b0, 8'd6); tick();
        check("tlb_refill_asid", 32'(rsp_exc), 32'd2);

        // Global invalid entry, then rewrite valid with a same-cycle lookup.
        set_wr(1'b0, 4'd7, 20'hC0010, 8'd1, 1'b1, 20'hABCDE, 1'b0, 1'b1, 1'b0); tick();
        set_req(32'hC001_0004, 1'b0, 1'b0, 8'd9); tick();
        check("global_invalid", 32'(rsp_exc), 32'd3);
        set_wr(1'b0, 4'd7, 20'hC0010, 8'd1, 1'b1, 20'hABCDE, 1'b1, 1'b1, 1'b0);
        set_req(32'hC001_0004, 1'b0, 1'b0, 8'd42); tick();
        check("same_cycle_prewrite", 32'(rsp_exc), 32'd3);
        set_req(32'hC001_0004, 1'b1, 1'b0, 8'd42); tick();
        check("global_hit_paddr", rsp_paddr, 32'hABCD_E004);

        // Random write at index 9, then probe it.
        guard = 0;
        while (rnd_model() != 9 && guard < 20) begin
            tick();
            guard++;
        end
        check("random_reach_9", 32'(random_o), 32'd9);
        set_wr(1'b1, 4'd0, 20'h00777, 8'd2, 1'b0, 20'h55555, 1'b1, 1'b1, 1'b1); tick();
        set_probe(20'h00777, 8'd2); tick();
        check("tlbwr_probe_hit", 32'(probe_hit), 32'd1);
        check("tlbwr_probe_idx", 32'(probe_index), 32'd9);

        // Randomized traffic.
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 3) == 0)
                set_wr(1'($urandom_range(0, 1)), 4'($urandom), pick_vpn(), 8'($urandom_range(0, 3)),
                       ($urandom_range(0, 3) == 0), 20'($urandom), 1'($urandom_range(0, 3) != 0),
                       1'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) != 0) begin
                if ($urandom_range(0, 3) == 0)
                    set_req({2'b10, 30'($urandom)}, 1'($urandom), ($urandom_range(0, 3) == 0),
                            8'($urandom_range(0, 3)));
                else
                    set_req({pick_vpn(), 12'($urandom)}, 1'($urandom), ($urandom_range(0, 3) == 0),
                            8'($urandom_range(0, 3)));
            end
            if ($urandom_range(0, 2) == 0)
                set_probe(pick_vpn(), 8'($urandom_range(0, 3)));
            tick();
        end

        // Reset while a request and a probe are in flight.
        set_req(32'h8000_0040, 1'b0, 1'b0, 8'd0);
        set_probe(20'h00400, 8'd5);
        @(posedge clk); #1;
        req_valid = 1'b0; probe_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midreset_probe_done", 32'(probe_done), 32'd0);
        model_clear();
        @(negedge clk) rst_n = 1'b1;
        #1;
        check("postreset_random", 32'(random_o), 32'd15);
        set_req(32'h0040_0ABC, 1'b0, 1'b0, 8'd5); tick();
        check("postreset_refill", 32'(rsp_exc), 32'd2);
        set_req(32'hC001_0004, 1'b0, 1'b0, 8'd42); tick();
        set_probe(20'h00777, 8'd2); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
